instr_enc: RTL and testbench

INSTR_ENC -- requirements
Module: instr_enc

---
 rtl/instr_enc.sv | 146 ++++++++++++++
 tb/tb_instr_enc.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_enc.sv
// RISC-V instruction field encoder with range checking, feeding a small
// in-order output FIFO. Erroneous requests are queued as a flagged NOP.
module instr_enc #(
  parameter int FIFO_DEPTH = 2  // power of two, 2..8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_cnt,
  output logic [3:0]  occupancy
);

  localparam int          PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  DEPTH4   = 4'(FIFO_DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_RET    = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JMP    = 7'b1101111;
  localparam logic [6:0] OP_SW     = 7'b0100011;

  logic [31:0] w_word;
  logic        w_bad;
  logic [31:0] w_enc_instr;
  logic        w_enc_err;
  logic        w_imm_i_ok;
  logic        w_imm_b_ok;
  logic        w_imm_j_ok;
  logic        w_imm_u_ok;
  logic        w_push;
  logic        w_pop;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic [15:0]   r_err_cnt;
  logic [31:0]   r_mem_instr [FIFO_DEPTH];
  logic          r_mem_err   [FIFO_DEPTH];

  // Each range check asks whether the immediate sign-extends from its field.
  assign w_imm_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_imm_b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign w_imm_j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign w_imm_u_ok = ~(|in_imm[11:0]);

  always_comb begin
    w_word = NOP_WORD;
    w_bad  = 1'b1;
    case (in_op)
      OP_R: begin
        w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
        w_bad  = 1'b0;
      end
      OP_ADDI, OP_LW, OP_RET: begin
        w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
        w_bad  = ~w_imm_i_ok;
      end
      OP_SW: begin
        w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
        w_bad  = ~w_imm_i_ok;
      end
      OP_BRANCH: begin
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], in_op};
        w_bad  = ~w_imm_b_ok;
      end
      OP_AUIPC, OP_LUI: begin
        w_word = {in_imm[31:12], in_rd, in_op};
        w_bad  = ~w_imm_u_ok;
      end
      OP_JMP: begin
        w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
        w_bad  = ~w_imm_j_ok;
      end
      default: begin
        w_word = NOP_WORD;
        w_bad  = 1'b1;
      end
    endcase
  end

  assign w_enc_instr = w_bad ? NOP_WORD : w_word;
  assign w_enc_err   = w_bad;

  // in_ready looks only at the current fill level, so a full FIFO never
  // accepts even when the head is being popped in the same cycle.
  assign in_ready  = (r_count != DEPTH4);
  assign out_valid = (r_count != 4'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= w_enc_instr;
      r_mem_err[r_wr_ptr]   <= w_enc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= 4'd0;
      r_err_cnt <= 16'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_enc_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  // Gating on the fill level keeps the outputs at zero while empty or in reset.
  assign out_instr = out_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
  assign out_err   = out_valid ? r_mem_err[r_rd_ptr]   : 1'b0;
  assign err_cnt   = r_err_cnt;
  assign occupancy = r_count;

endmodule

// File: tb/tb_instr_enc.sv
// Bench for instr_enc: directed scenarios plus randomized traffic checked
// against a queue-based reference model computed from the encoding rules.
module tb_instr_enc;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_cnt;
  logic [3:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  logic [32:0] model_q[$];
  int          model_err = 0;

  instr_enc #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .err_cnt(err_cnt), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder: ranges expressed as signed integer bounds.
  function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    longint      si;
    bit          ok;
    logic [31:0] w;
    logic [31:0] base;
    si   = longint'($signed(imm));
    ok   = 1'b0;
    w    = 32'h0;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (op)
      7'b0110011: begin
        ok = 1'b1;
        w  = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        ok = (si >= -2048) && (si <= 2047);
        w  = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
      end
      7'b0100011: begin
        ok = (si >= -2048) && (si <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
      end
      7'b1100011: begin
        ok = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
        w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
             | base | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      end
      7'b0010111, 7'b0110111: begin
        ok = (imm % 4096) == 0;
        w  = imm | (32'(rd) << 7) | 32'(op);
      end
      7'b1101111: begin
        ok = (si >= -1048576) && (si <= 1048575) && (si % 2 == 0);
        w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
             | (32'(rd) << 7) | 32'(op);
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
  endfunction

  // One clock: optionally compare outputs to the model, then advance both.
  task automatic cycle(input bit do_chk);
    bit          push;
    bit          pop;
    logic [32:0] w;
    if (do_chk) begin
      chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      chk("occupancy", 32'(occupancy), 32'(model_q.size()));
      chk("err_cnt", 32'(err_cnt), 32'(model_err));
      if (model_q.size() != 0) begin
        chk("out_instr", out_instr, model_q[0][31:0]);
        chk("out_err", 32'(out_err), 32'(model_q[0][32]));
      end
    end
    push = in_valid && (model_q.size() != DEPTH);
    pop  = (model_q.size() != 0) && out_ready;
    w    = model_enc(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    @(posedge clk);
    #1;
    if (pop) void'(model_q.pop_front());
    if (push) begin
      model_q.push_back(w);
      if (w[32] && model_err != 65535) model_err++;
    end
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = 7'($urandom);
    in_imm    = imm;
  endtask

  task automatic rand_req();
    logic [6:0] ops [10];
    int         sel;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0010111,
            7'b0110111, 7'b1100011, 7'b1101111, 7'b0100011, 7'b1111111};
    in_op = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 9) == 0) in_op = 7'($urandom);
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    in_funct3 = 3'($urandom);
    in_funct7 = 7'($urandom);
    sel = $urandom_range(0, 4);
    case (sel)
      0: in_imm = $urandom;
      1: in_imm = 32'($signed(12'($urandom)));
      2: in_imm = 32'($signed(13'($urandom)));
      3: in_imm = 32'($signed(21'($urandom)));
      default: in_imm = $urandom & 32'hFFFF_F000;
    endcase
    in_valid = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    #2;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ADDI, accepted on the first edge after release
    out_ready = 1'b1;
    set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
    cycle(1);
    in_valid = 1'b0;
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_word", out_instr, 32'hFFF0_0093);
    chk("addi_err", 32'(out_err), 0);
    cycle(1);

    set_req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
    cycle(1);
    in_valid = 1'b0;
    chk("br_word", out_instr, 32'h0020_8463);
    cycle(1);
    set_req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_1000);
    cycle(1);
    in_valid = 1'b0;
    chk("br_bad_word", out_instr, 32'h0000_0013);
    chk("br_bad_err", 32'(out_err), 1);
    chk("br_bad_cnt", 32'(err_cnt), 1);
    cycle(1);

    set_req(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    cycle(1);
    in_valid = 1'b0;
    chk("lui_word", out_instr, 32'h1234_52B7);
    cycle(1);
    set_req(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
    cycle(1);
    in_valid = 1'b0;
    chk("jmp_bad_word", out_instr, 32'h0000_0013);
    chk("jmp_bad_err", 32'(out_err), 1);
    cycle(1);

    // Backpressure with three back-to-back requests
    out_ready = 1'b0;
    set_req(7'b0110011, 5'd3, 5'd4, 5'd5, 3'd1, 32'h0);
    cycle(1);
    set_req(7'b0010011, 5'd6, 5'd7, 5'd0, 3'd2, 32'd100);
    cycle(1);
    set_req(7'b0100011, 5'd0, 5'd8, 5'd9, 3'd2, 32'hFFFF_FFF0);
    cycle(1);
    chk("bp_ready", 32'(in_ready), 0);
    chk("bp_occ", 32'(occupancy), 2);
    out_ready = 1'b1;
    cycle(1);
    chk("bp_drain_occ", 32'(occupancy), 1);
    chk("bp_second", out_instr, 32'h0643_A313);
    cycle(1);
    in_valid = 1'b0;
    cycle(1);
    cycle(1);

    // Reset mid-stream with one entry queued
    out_ready = 1'b0;
    set_req(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0);
    cycle(1);
    in_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_cnt", 32'(err_cnt), 0);
    model_q.delete();
    model_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle(1);
    chk("post_rst_valid", 32'(out_valid), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_req();
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle(1);
    end

    // Error counter saturation
    out_ready = 1'b1;
    set_req(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
    for (int i = 0; i < 65540; i++) cycle(0);
    chk("sat_cnt", 32'(err_cnt), 32'hFFFF);
    cycle(1);
    chk("sat_hold", 32'(err_cnt), 32'hFFFF);
    in_valid = 1'b0;
    cycle(1);
    cycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
